// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line input plus received-byte outputs of the UART receiver.
// The master side is the receiver. It samples rx and drives rcv/data/err/busy.
// The slave side is whoever owns the pin and consumes received bytes.
interface uart_rx_if;
  logic       rx;
  logic       rcv;
  logic [7:0] data;
  logic       err;
  logic       busy;

  modport master (input rx, output rcv, output data, output err, output busy);
  modport slave  (output rx, input rcv, input data, input err, input busy);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous receiver producing parallel bytes, a one-cycle rcv strobe and a framing-error strobe.
// Latency: pin edge + 2 (sync) + CPB/2 + 9*CPB + 1 clocks to rcv; data updates on the same edge as rcv.
// Backpressure: none; the consumer must take each byte during its rcv pulse, because the next good byte overwrites data.
module uart_rx #(
  parameter int clockRate = 12_000_000,
  parameter int baudRate  = 115200
) (
  input  logic     clk,
  input  logic     reset,
  uart_rx_if.master line
);

  localparam int CPB = clockRate / baudRate;
  // Counter holds at most CPB-1. The guard keeps the width legal so the CPB check below is what reports.
  localparam int CW  = (CPB > 2) ? $clog2(CPB) : 1;
  localparam logic [CW-1:0] HALF_LOAD = CW'((CPB / 2 > 0) ? (CPB / 2 - 1) : 0);
  localparam logic [CW-1:0] FULL_LOAD = CW'((CPB > 0) ? (CPB - 1) : 0);

  if (CPB < 2) begin : g_cpb_check
    $error("uart_rx: clockRate/baudRate must be at least 2 clocks per bit");
  end

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    STOP     = 3'd3,
    WAITHIGH = 3'd4
  } state_t;

  // Synchronizer and edge-detect state.
  logic [1:0] sync_q;
  logic       rxs;
  logic       rxs_prev;
  // Marks the sync stages that hold real pin samples instead of reset values.
  logic [1:0] seeded;
  // Set once the pin has really been seen high since reset. A line that is low out of reset cannot start a frame.
  logic       armed;
  logic       start_edge;

  // Frame state.
  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [2:0]      idx, idx_nxt;
  logic [7:0]      shreg, shreg_nxt;
  logic            rcv_nxt, err_nxt;

  // Output registers.
  logic            rcv_q, err_q;
  logic [7:0]      data_q;

  assign rxs        = sync_q[1];
  assign start_edge = armed & rxs_prev & ~rxs;

  // Two-flop synchronizer, previous-sample flop and the arming flag for the start detector.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q   <= 2'b11;
      rxs_prev <= 1'b1;
      seeded   <= 2'b00;
      armed    <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], line.rx};
      rxs_prev <= rxs;
      seeded   <= {seeded[0], 1'b1};
      armed    <= armed | (seeded[1] & rxs);
    end
  end

  // FSM state, bit counter, bit index and shift register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      shreg <= shreg_nxt;
    end
  end

  // Next state: centre-of-bit sampling driven by a down-counter reloaded once per bit.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    shreg_nxt = shreg;
    rcv_nxt   = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (start_edge) begin
          state_nxt = START;
          cnt_nxt   = HALF_LOAD;
        end
      end
      START: begin
        if (cnt == '0) begin
          if (rxs) begin
            // The line went back high by mid start bit, so treat it as a glitch.
            state_nxt = IDLE;
          end else begin
            state_nxt = DATA;
            idx_nxt   = 3'd0;
            cnt_nxt   = FULL_LOAD;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      DATA: begin
        if (cnt == '0) begin
          // LSB arrives first. Shift right so bit 0 ends up in shreg[0] after eight samples.
          shreg_nxt = {rxs, shreg[7:1]};
          cnt_nxt   = FULL_LOAD;
          if (idx == 3'd7) begin
            state_nxt = STOP;
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      STOP: begin
        if (cnt == '0) begin
          if (rxs) begin
            rcv_nxt   = 1'b1;
            state_nxt = IDLE;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = WAITHIGH;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      WAITHIGH: begin
        // Wait here for the line to go high again, so a held break reports only one error.
        if (rxs) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Registered strobes. data only loads on a good stop bit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rcv_q  <= 1'b0;
      err_q  <= 1'b0;
      data_q <= 8'h00;
    end else begin
      rcv_q <= rcv_nxt;
      err_q <= err_nxt;
      if (rcv_nxt) begin
        data_q <= shreg;
      end
    end
  end

  assign line.rcv  = rcv_q;
  assign line.err  = err_q;
  assign line.data = data_q;
  assign line.busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives 8N1 frames into a CPB=2 and a CPB=16 receiver.
// Expected rcv/err events are queued when frames are sent and compared as the receivers emit them.
// Also covers reset values, glitch rejection, break handling and reset mid-frame.
module tb_uart_rx;

  logic clk;
  logic rst2;
  logic rst16;

  uart_rx_if if2();
  uart_rx_if if16();

  uart_rx #(.clockRate(230400),  .baudRate(115200)) dut2  (.clk(clk), .reset(rst2),  .line(if2));
  uart_rx #(.clockRate(1843200), .baudRate(115200)) dut16 (.clk(clk), .reset(rst16), .line(if16));

  int checks = 0;
  int errors = 0;

  // Entry: bit9 = rcv&err together (never expected), bit8 = err event, [7:0] = data value expected on that cycle.
  logic [9:0] q2[$];
  logic [9:0] q16[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Event monitors, sampled on the falling edge.
  always @(negedge clk) begin
    if (if2.rcv === 1'b1 || if2.err === 1'b1) begin
      logic [9:0] exp2;
      exp2 = (q2.size() > 0) ? q2.pop_front() : 10'h3FF;
      chk("dut2_event", {22'd0, if2.rcv & if2.err, if2.err, if2.data}, {22'd0, exp2});
    end
  end

  always @(negedge clk) begin
    if (if16.rcv === 1'b1 || if16.err === 1'b1) begin
      logic [9:0] exp16;
      exp16 = (q16.size() > 0) ? q16.pop_front() : 10'h3FF;
      chk("dut16_event", {22'd0, if16.rcv & if16.err, if16.err, if16.data}, {22'd0, exp16});
    end
  end

  // Hold the selected line at v for n clocks, starting from a falling edge.
  task automatic hold(input bit sel16, input logic v, input int n);
    if (sel16) if16.rx = v;
    else       if2.rx  = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input bit sel16, input logic [7:0] b, input int nstop, input logic stopv);
    int cpb;
    cpb = sel16 ? 16 : 2;
    hold(sel16, 1'b0, cpb);
    for (int i = 0; i < 8; i++) hold(sel16, b[i], cpb);
    for (int s = 0; s < nstop; s++) hold(sel16, stopv, cpb);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((q2.size() != 0 || q16.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
  endtask

  logic [7:0] trio[3]   = '{8'h00, 8'hA5, 8'h3C};
  logic [7:0] loader[9] = '{8'h03, 8'h12, 8'h34, 8'h56, 8'h78, 8'h89, 8'hAB, 8'hCD, 8'hEF};
  logic [7:0] b77;

  initial begin
    rst2    = 1'b0;
    rst16   = 1'b0;
    if2.rx  = 1'b1;
    if16.rx = 1'b1;
    repeat (4) @(negedge clk);

    // Reset values.
    chk("rst2_data",  {24'd0, if2.data}, 32'h00);
    chk("rst2_rcv",   {31'd0, if2.rcv},  32'd0);
    chk("rst2_err",   {31'd0, if2.err},  32'd0);
    chk("rst2_busy",  {31'd0, if2.busy}, 32'd0);
    chk("rst16_data", {24'd0, if16.data}, 32'h00);
    chk("rst16_rcv",  {31'd0, if16.rcv},  32'd0);
    chk("rst16_err",  {31'd0, if16.err},  32'd0);
    chk("rst16_busy", {31'd0, if16.busy}, 32'd0);

    rst2  = 1'b1;
    rst16 = 1'b1;
    repeat (6) @(negedge clk);

    // CPB=2: 0xFF with two stop bits.
    q2.push_back({2'b00, 8'hFF});
    send(1'b0, 8'hFF, 2, 1'b1);
    drain(200);

    // CPB=2: back-to-back frames with a single stop bit.
    foreach (trio[i]) begin
      q2.push_back({2'b00, trio[i]});
      send(1'b0, trio[i], 1, 1'b1);
    end
    drain(200);

    // CPB=2: loader stream, count byte then eight payload bytes.
    foreach (loader[i]) begin
      q2.push_back({2'b00, loader[i]});
      send(1'b0, loader[i], 1, 1'b1);
    end
    drain(400);

    // CPB=16: good byte, then a framing error that must leave data at 0x5A.
    q16.push_back({2'b00, 8'h5A});
    send(1'b1, 8'h5A, 1, 1'b1);
    hold(1'b1, 1'b1, 16);
    q16.push_back({2'b01, 8'h5A});
    send(1'b1, 8'hC3, 1, 1'b0);
    // Break held for 30 bit times. Any further err shows up as an unexpected event.
    hold(1'b1, 1'b0, 30 * 16);
    chk("brk_data", {24'd0, if16.data}, 32'h5A);
    hold(1'b1, 1'b1, 32);
    q16.push_back({2'b00, 8'h81});
    send(1'b1, 8'h81, 1, 1'b1);
    drain(1000);
    hold(1'b1, 1'b1, 16);

    // CPB=16: 3-clock low glitch. A start is seen, then the frame is abandoned at mid start bit.
    hold(1'b1, 1'b0, 3);
    hold(1'b1, 1'b1, 2);
    chk("glitch_busy_hi", {31'd0, if16.busy}, 32'd1);
    repeat (8) @(negedge clk);
    chk("glitch_busy_lo", {31'd0, if16.busy}, 32'd0);
    repeat (40) @(negedge clk);

    // CPB=16: reset in the middle of bit 4 of 0x77 drops the byte without any pulse.
    b77 = 8'h77;
    hold(1'b1, 1'b0, 16);
    for (int i = 0; i < 4; i++) hold(1'b1, b77[i], 16);
    hold(1'b1, b77[4], 8);
    rst16 = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_rcv",  {31'd0, if16.rcv},  32'd0);
    chk("midrst_err",  {31'd0, if16.err},  32'd0);
    chk("midrst_busy", {31'd0, if16.busy}, 32'd0);
    chk("midrst_data", {24'd0, if16.data}, 32'h00);
    if16.rx = 1'b1;
    repeat (4) @(negedge clk);
    rst16 = 1'b1;
    repeat (40) @(negedge clk);
    chk("postrst_busy", {31'd0, if16.busy}, 32'd0);
    q16.push_back({2'b00, 8'h12});
    send(1'b1, 8'h12, 1, 1'b1);
    drain(1000);
    chk("postrst_data", {24'd0, if16.data}, 32'h12);

    // Every queued event must have been produced.
    chk("dut2_left",  q2.size(),  32'd0);
    chk("dut16_left", q16.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
